// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: state encoding and requester count.
package rr_arbiter8_pkg;

  localparam int N = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter8_pick8.sv
// Combinational round-robin pick: rotate req so ptr lands at bit 0, find first set, un-rotate.
module rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic [7:0] pick,
  output logic [2:0] idx,
  output logic       any_req
);

  logic [15:0] dbl;
  logic [7:0]  rot;
  logic [2:0]  ridx;
  logic        found;

  always_comb begin
    dbl     = {req, req} >> ptr;
    rot     = dbl[7:0];
    ridx    = 3'd0;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && rot[i]) begin
        ridx  = 3'(i);
        found = 1'b1;
      end
    end
    // Adding ptr back in 3-bit arithmetic undoes the rotation modulo 8.
    idx     = ridx + ptr;
    any_req = |req;
    pick    = any_req ? (8'b1 << idx) : 8'b0;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Two-state round-robin arbiter: grants one requester until it strobes done, then rotates priority.
module rr_arbiter8 #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic         dbg_state,
  output logic [2:0]   dbg_ptr
);
  import rr_arbiter8_pkg::*;

  // Handshake: req is a level held by each requester; grant/grant_valid are registered and
  // held until the holder pulses done for one cycle in GRANT. done is ignored outside GRANT.

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] gidx_q, gidx_d;
  logic [7:0] grant_q, grant_d;
  logic       valid_q, valid_d;

  logic [7:0] pick;
  logic [2:0] pick_idx;
  logic       any_req;

  rr_pick8 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .pick    (pick),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          gidx_d  = pick_idx;
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Pointer moves past the holder only on release; 3-bit wrap gives 7 -> 0.
        if (done) begin
          grant_d = 8'b0;
          valid_d = 1'b0;
          ptr_d   = gidx_q + 3'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      gidx_q  <= 3'd0;
      grant_q <= 8'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign dbg_state   = state_q;
  assign dbg_ptr     = ptr_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: vector table of per-cycle expectations plus fairness/latency sequences.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic       grant_valid;
  logic       dbg_state;
  logic [2:0] dbg_ptr;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] exp_grant;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  rr_arbiter8 #(.N(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .dbg_state   (dbg_state),
    .dbg_ptr     (dbg_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step(input logic r, input logic [7:0] rq, input logic d);
    rst  = r;
    req  = rq;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [7:0] rq, input logic d, input logic [7:0] eg);
    vec_t v;
    v.rst = r; v.req = rq; v.done = d; v.exp_grant = eg;
    vecs.push_back(v);
  endtask

  // scoreboard
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_outputs(input string name, input logic [7:0] eg);
    logic [7:0] ev;
    ev = {7'b0, (eg != 8'h00)};
    check({name, ".grant"}, grant, eg);
    check({name, ".valid"}, {7'b0, grant_valid}, ev);
    check({name, ".onehot"}, {7'b0, ($countones(grant) <= 1)}, 8'h01);
  endtask

  initial begin
    int cyc;
    logic [7:0] e;
    rst = 1'b1; req = 8'h00; done = 1'b0;

    // reset with activity on req/done must still hold everything off
    add(1, 8'hFF, 1, 8'h00);
    add(1, 8'hFF, 0, 8'h00);
    // basic grant, hold for 10 cycles while req changes, release, ptr=1 skips 0
    add(0, 8'h05, 0, 8'h01);
    for (int i = 0; i < 10; i++) add(0, (i % 2 == 0) ? 8'h00 : 8'hFE, 0, 8'h01);
    add(0, 8'h05, 1, 8'h00);
    add(0, 8'h05, 0, 8'h04);
    add(0, 8'h00, 1, 8'h00);          // ptr -> 3
    // holder drops req while granted
    add(0, 8'h08, 0, 8'h08);
    add(0, 8'h00, 0, 8'h08);
    add(0, 8'h00, 0, 8'h08);
    add(0, 8'h00, 0, 8'h08);
    add(0, 8'h00, 1, 8'h00);          // ptr -> 4
    // reset during grant drops it with no release semantics
    add(0, 8'h20, 0, 8'h20);
    add(1, 8'h20, 1, 8'h00);
    add(0, 8'h21, 0, 8'h01);          // ptr was reset to 0
    add(0, 8'h21, 1, 8'h00);          // ptr -> 1
    // done in IDLE ignored for 5 cycles
    for (int i = 0; i < 5; i++) add(0, 8'h00, 1, 8'h00);
    add(0, 8'h80, 0, 8'h80);
    add(0, 8'h80, 1, 8'h00);          // ptr wraps -> 0
    // rotating pick across the wrap: ptr=5, req=13 -> bit 0
    add(0, 8'h10, 0, 8'h10);
    add(0, 8'h10, 1, 8'h00);          // ptr -> 5
    add(0, 8'h13, 0, 8'h01);
    add(0, 8'h13, 1, 8'h00);          // ptr -> 1
    add(0, 8'h13, 0, 8'h02);
    add(0, 8'h13, 1, 8'h00);          // ptr -> 2
    add(0, 8'h13, 0, 8'h10);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].done);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_grant);
    end

    // reset during grant leaves ptr at 0, not holder+1
    step(0, 8'h13, 0);
    step(1, 8'h00, 0);
    check("rst_ptr", {5'b0, dbg_ptr}, 8'h00);
    check_outputs("rst_out", 8'h00);

    // fairness with all requests held and done always high: 01,00,02,00,...,80,00,01
    for (int k = 0; k < 9; k++) begin
      e = 8'h01 << (k % 8);
      exp_q.push_back(e);
      exp_q.push_back(8'h00);
    end
    while (exp_q.size() > 0) begin
      step(0, 8'hFF, 1);
      e = exp_q.pop_front();
      check_outputs("fair", e);
    end
    check("fair_ptr", {5'b0, dbg_ptr}, 8'h01);

    // first-grant latency from IDLE is exactly one edge (bounded wait)
    step(1, 8'h00, 0);
    cyc = 0;
    req = 8'h40;
    do begin
      step(0, 8'h40, 0);
      cyc++;
    end while (!grant_valid && cyc < 8);
    check("latency", 8'(cyc), 8'h01);
    check_outputs("latency_out", 8'h40);
    step(0, 8'h40, 1);
    check("release_ptr", {5'b0, dbg_ptr}, 8'h07);
    check_outputs("gap", 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
